// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_if
// Description : Bundle between the multi-cycle controller and its datapath.
//               master = controller side (drives strobes, reads opcode and
//               memory ready); slave = datapath side.
// Signals     : op[5:0] (IR opcode), mem_ready, pcwrite, pcwritecond, iord,
//               memread, memwrite, irwrite, memtoreg, regdst, regwrite,
//               alusrca, alusrcb[1:0], aluop1, aluop0, pcsource[1:0],
//               illegal_op, mem_err, state_dbg[3:0]
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_if;
    logic [5:0] op;
    logic       mem_ready;
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       aluop1;
    logic       aluop0;
    logic [1:0] pcsource;
    logic       illegal_op;
    logic       mem_err;
    logic [3:0] state_dbg;

    modport master (
        input  op, mem_ready,
        output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
               memtoreg, regdst, regwrite, alusrca, alusrcb, aluop1, aluop0,
               pcsource, illegal_op, mem_err, state_dbg
    );

    modport slave (
        output op, mem_ready,
        input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
               memtoreg, regdst, regwrite, alusrca, alusrcb, aluop1, aluop0,
               pcsource, illegal_op, mem_err, state_dbg
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Moore FSM sequencing a multi-cycle MIPS-lite datapath
//               (shared ALU, unified memory). Strobes are decoded from state.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - multicycle_control_if.master (opcode/mem_ready in,
//                       datapath strobes, error pulses and state_dbg out)
// Options     : MEM_WAIT_EN - FETCH/MEMRD/MEMWR hold on mem_ready=0 with a
//               TIMEOUT-cycle watchdog raising mem_err. Undefined: mem_ready
//               is ignored and mem_err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RCOMP  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   w_go;   // memory access may complete this cycle

`ifdef MEM_WAIT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_err_q;
    logic             w_mem_state;
    logic             w_tmo;

    assign w_mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                         (state_q == S_MEMWR);
    assign w_go        = bus.mem_ready;
    // A ready arriving in the same cycle the counter hits TIMEOUT wins.
    assign w_tmo       = w_mem_state && !bus.mem_ready &&
                         (cnt_q == CNT_W'(TIMEOUT));
    // Count stalled cycles; any exit (success or timeout) clears the count.
    assign cnt_d       = (w_mem_state && !bus.mem_ready && !w_tmo) ?
                         cnt_q + 1'b1 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            mem_err_q <= w_tmo;
        end
    end

    assign bus.mem_err = mem_err_q;
`else
    localparam int c_unused_cfg = TIMEOUT + CNT_W;
    logic w_unused;

    assign w_go        = 1'b1;
    assign w_unused    = bus.mem_ready;
    assign bus.mem_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        illegal_d       = 1'b0;
        bus.pcwrite     = 1'b0;
        bus.pcwritecond = 1'b0;
        bus.iord        = 1'b0;
        bus.memread     = 1'b0;
        bus.memwrite    = 1'b0;
        bus.irwrite     = 1'b0;
        bus.memtoreg    = 1'b0;
        bus.regdst      = 1'b0;
        bus.regwrite    = 1'b0;
        bus.alusrca     = 1'b0;
        bus.alusrcb     = 2'b00;
        bus.aluop1      = 1'b0;
        bus.aluop0      = 1'b0;
        bus.pcsource    = 2'b00;

        case (state_q)
            S_FETCH: begin
                bus.memread = 1'b1;
                bus.alusrcb = 2'b01;
                // PC/IR load only on the completing cycle so PC advances once.
                if (w_go) begin
                    bus.irwrite = 1'b1;
                    bus.pcwrite = 1'b1;
                    state_d     = S_DECODE;
                end
            end
            S_DECODE: begin
                bus.alusrcb = 2'b11;
                case (bus.op)
                    c_OP_RTYPE:       state_d = S_EXEC;
                    c_OP_LW, c_OP_SW: state_d = S_MEMADR;
                    c_OP_BEQ:         state_d = S_BRANCH;
                    c_OP_J:           state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                // Only lw/sw reach here; the IR still holds the opcode.
                state_d     = (bus.op == c_OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.memread = 1'b1;
                bus.iord    = 1'b1;
                if (w_go) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                bus.memwrite = 1'b1;
                bus.iord     = 1'b1;
                if (w_go) state_d = S_FETCH;
            end
            S_EXEC: begin
                bus.alusrca = 1'b1;
                bus.aluop1  = 1'b1;
                state_d     = S_RCOMP;
            end
            S_RCOMP: begin
                bus.regwrite = 1'b1;
                bus.regdst   = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                bus.alusrca     = 1'b1;
                bus.aluop0      = 1'b1;
                bus.pcwritecond = 1'b1;
                bus.pcsource    = 2'b01;
                state_d         = S_FETCH;
            end
            S_JUMP: begin
                bus.pcwrite  = 1'b1;
                bus.pcsource = 2'b10;
                state_d      = S_FETCH;
            end
            default: state_d = S_FETCH;   // codes 10-15 recover to FETCH
        endcase

`ifdef MEM_WAIT_EN
        if (w_tmo) state_d = S_FETCH;
`endif
    end

    assign bus.illegal_op = illegal_q;
    assign bus.state_dbg  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Table-driven self-checking bench for multicycle_control.
//               Each row gives the inputs for one cycle plus the expected
//               state and strobe vector for that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    // Strobe vector field order:
    // pcwrite pcwritecond iord memread memwrite irwrite memtoreg regdst
    // regwrite alusrca alusrcb[1:0] aluop1 aluop0 pcsource[1:0] illegal mem_err
    localparam logic [17:0] c_FETCH  = 18'b1_0_0_1_0_1_0_0_0_0_01_0_0_00_0_0;
    localparam logic [17:0] c_FSTALL = 18'b0_0_0_1_0_0_0_0_0_0_01_0_0_00_0_0;
    localparam logic [17:0] c_DECODE = 18'b0_0_0_0_0_0_0_0_0_0_11_0_0_00_0_0;
    localparam logic [17:0] c_MEMADR = 18'b0_0_0_0_0_0_0_0_0_1_10_0_0_00_0_0;
    localparam logic [17:0] c_MEMRD  = 18'b0_0_1_1_0_0_0_0_0_0_00_0_0_00_0_0;
    localparam logic [17:0] c_MEMWB  = 18'b0_0_0_0_0_0_1_0_1_0_00_0_0_00_0_0;
    localparam logic [17:0] c_MEMWR  = 18'b0_0_1_0_1_0_0_0_0_0_00_0_0_00_0_0;
    localparam logic [17:0] c_EXEC   = 18'b0_0_0_0_0_0_0_0_0_1_00_1_0_00_0_0;
    localparam logic [17:0] c_RCOMP  = 18'b0_0_0_0_0_0_0_1_1_0_00_0_0_00_0_0;
    localparam logic [17:0] c_BRANCH = 18'b0_1_0_0_0_0_0_0_0_1_00_0_1_01_0_0;
    localparam logic [17:0] c_JUMP   = 18'b1_0_0_0_0_0_0_0_0_0_00_0_0_10_0_0;
    localparam logic [17:0] c_ILL    = 18'b0_0_0_0_0_0_0_0_0_0_00_0_0_00_1_0;
    localparam logic [17:0] c_MERR   = 18'b0_0_0_0_0_0_0_0_0_0_00_0_0_00_0_1;

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [17:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_err;
    int   n_chk;
    vec_t vq[$];

    multicycle_control_if bus_if ();

    multicycle_control #(
        .TIMEOUT (3),
        .CNT_W   (8)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [17:0] w_act;
    assign w_act = {bus_if.pcwrite, bus_if.pcwritecond, bus_if.iord,
                    bus_if.memread, bus_if.memwrite, bus_if.irwrite,
                    bus_if.memtoreg, bus_if.regdst, bus_if.regwrite,
                    bus_if.alusrca, bus_if.alusrcb, bus_if.aluop1,
                    bus_if.aluop0, bus_if.pcsource, bus_if.illegal_op,
                    bus_if.mem_err};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] op, input logic rdy,
                       input logic [3:0] st, input logic [17:0] exp);
        vec_t v;
        v.op  = op;
        v.rdy = rdy;
        v.st  = st;
        v.exp = exp;
        vq.push_back(v);
    endtask

    // Apply each row, check the current cycle, then advance one clock.
    task automatic run_table(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            bus_if.op        = vq[i].op;
            bus_if.mem_ready = vq[i].rdy;
            #1;
            chk($sformatf("%s[%0d].state", tag, i), 32'(bus_if.state_dbg),
                32'(vq[i].st));
            chk($sformatf("%s[%0d].strobes", tag, i), 32'(w_act),
                32'(vq[i].exp));
            @(posedge clk);
            #1;
        end
        vq.delete();
    endtask

    initial begin
        n_err            = 0;
        n_chk            = 0;
        rst_n            = 1'b0;
        bus_if.op        = 6'h00;
        bus_if.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // lw: 5 cycles
        add(6'h23, 1'b1, 4'd0, c_FETCH);
        add(6'h23, 1'b1, 4'd1, c_DECODE);
        add(6'h23, 1'b1, 4'd2, c_MEMADR);
        add(6'h23, 1'b1, 4'd3, c_MEMRD);
        add(6'h23, 1'b1, 4'd4, c_MEMWB);
        // sw: 4 cycles
        add(6'h2B, 1'b1, 4'd0, c_FETCH);
        add(6'h2B, 1'b1, 4'd1, c_DECODE);
        add(6'h2B, 1'b1, 4'd2, c_MEMADR);
        add(6'h2B, 1'b1, 4'd5, c_MEMWR);
        // R-type: 4 cycles
        add(6'h00, 1'b1, 4'd0, c_FETCH);
        add(6'h00, 1'b1, 4'd1, c_DECODE);
        add(6'h00, 1'b1, 4'd6, c_EXEC);
        add(6'h00, 1'b1, 4'd7, c_RCOMP);
        // beq: 3 cycles
        add(6'h04, 1'b1, 4'd0, c_FETCH);
        add(6'h04, 1'b1, 4'd1, c_DECODE);
        add(6'h04, 1'b1, 4'd8, c_BRANCH);
        // j: 3 cycles
        add(6'h02, 1'b1, 4'd0, c_FETCH);
        add(6'h02, 1'b1, 4'd1, c_DECODE);
        add(6'h02, 1'b1, 4'd9, c_JUMP);
        // unsupported opcode: back to FETCH, illegal pulse for one cycle
        add(6'h0F, 1'b1, 4'd0, c_FETCH);
        add(6'h0F, 1'b1, 4'd1, c_DECODE);
        add(6'h00, 1'b1, 4'd0, c_FETCH | c_ILL);
        add(6'h00, 1'b1, 4'd1, c_DECODE);
        run_table("base");

        // Now in EXEC: assert reset mid-instruction, away from the edge.
        chk("pre_reset.state", 32'(bus_if.state_dbg), 32'd6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset.state", 32'(bus_if.state_dbg), 32'd0);
        chk("async_reset.strobes", 32'(w_act), 32'(c_FETCH));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_reset.state", 32'(bus_if.state_dbg), 32'd0);
        chk("post_reset.strobes", 32'(w_act), 32'(c_FETCH));

`ifdef MEM_WAIT_EN
        // Stall FETCH once, then MEMRD held 3 cycles by two not-ready cycles.
        add(6'h23, 1'b0, 4'd0, c_FSTALL);
        add(6'h23, 1'b1, 4'd0, c_FETCH);
        add(6'h23, 1'b1, 4'd1, c_DECODE);
        add(6'h23, 1'b1, 4'd2, c_MEMADR);
        add(6'h23, 1'b0, 4'd3, c_MEMRD);
        add(6'h23, 1'b0, 4'd3, c_MEMRD);
        add(6'h23, 1'b1, 4'd3, c_MEMRD);
        add(6'h23, 1'b1, 4'd4, c_MEMWB);
        // sw with mem_ready stuck low: timeout after counter reaches 3.
        add(6'h2B, 1'b1, 4'd0, c_FETCH);
        add(6'h2B, 1'b1, 4'd1, c_DECODE);
        add(6'h2B, 1'b1, 4'd2, c_MEMADR);
        add(6'h2B, 1'b0, 4'd5, c_MEMWR);
        add(6'h2B, 1'b0, 4'd5, c_MEMWR);
        add(6'h2B, 1'b0, 4'd5, c_MEMWR);
        add(6'h2B, 1'b0, 4'd5, c_MEMWR);
        add(6'h23, 1'b1, 4'd0, c_FETCH | c_MERR);
        // Ready arriving exactly when the counter equals TIMEOUT succeeds.
        add(6'h23, 1'b1, 4'd1, c_DECODE);
        add(6'h23, 1'b1, 4'd2, c_MEMADR);
        add(6'h23, 1'b0, 4'd3, c_MEMRD);
        add(6'h23, 1'b0, 4'd3, c_MEMRD);
        add(6'h23, 1'b0, 4'd3, c_MEMRD);
        add(6'h23, 1'b1, 4'd3, c_MEMRD);
        add(6'h23, 1'b1, 4'd4, c_MEMWB);
        add(6'h00, 1'b1, 4'd0, c_FETCH);
        run_table("wait");
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
